mac_sequencer: RTL and testbench



---
 rtl/mac_sequencer.sv | 126 ++++++++++++
 tb/tb_mac_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_sequencer                                                |
// | Description : Control stage in front of a registered MAC datapath. Takes   |
// |               a dot-product job (bias, length) and feeds the MAC its       |
// |               enable, bias-load select, bias and operand pairs taken from  |
// |               a valid/ready source. The final accumulator value is         |
// |               returned on a valid/ready result port.                       |
// | Optional    : `define MAC_SEQ_ABORT_EN adds an ABORT input that cancels a  |
// |               job in LOAD, ACCUM or DRAIN and returns no result.           |
// | Ports       : CLKEXT, RST_CTRL (sync, active-high)                         |
// |               START/LEN/BIAS       job request, sampled only in IDLE       |
// |               OP_VALID/OP_READY/OP_A/OP_B   operand stream                 |
// |               EN_MAC/RST_MAC/BIAS_MAC/A_MAC/B_MAC   MAC controls           |
// |               MAC_Y                registered MAC accumulator              |
// |               RES_VALID/RES_READY/RES_DATA   result port                   |
// |               BUSY                 high in every state except IDLE         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic               CLKEXT,
    input  logic               RST_CTRL,
`ifdef MAC_SEQ_ABORT_EN
    input  logic               ABORT,
`endif
    input  logic               START,
    input  logic [LEN_W-1:0]   LEN,
    input  logic [7:0]         BIAS,
    input  logic               OP_VALID,
    input  logic [7:0]         OP_A,
    input  logic [7:0]         OP_B,
    output logic               OP_READY,
    output logic               EN_MAC,
    output logic               RST_MAC,
    output logic [7:0]         BIAS_MAC,
    output logic [7:0]         A_MAC,
    output logic [7:0]         B_MAC,
    input  logic [15:0]        MAC_Y,
    output logic               RES_VALID,
    output logic [15:0]        RES_DATA,
    input  logic               RES_READY,
    output logic               BUSY
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LOAD   = 3'd1;
    localparam logic [2:0] c_S_ACCUM  = 3'd2;
    localparam logic [2:0] c_S_DRAIN  = 3'd3;
    localparam logic [2:0] c_S_OUTPUT = 3'd4;

    localparam logic [LEN_W-1:0] c_CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_CNT_ZERO = '0;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_bias;
    logic [15:0]      r_res;
    logic             w_abort;
    logic             w_accept;

    // Abort only matters while a job is in flight towards the MAC; once the
    // result is sitting in OUTPUT it must be delivered.
`ifdef MAC_SEQ_ABORT_EN
    assign w_abort = ABORT && ((r_state == c_S_LOAD) || (r_state == c_S_ACCUM) ||
                               (r_state == c_S_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    // Abort wins over a same-cycle operand handshake, so ready is withdrawn
    // as well, keeping the source from believing its pair was consumed.
    assign OP_READY = (r_state == c_S_ACCUM) && !w_abort;
    assign w_accept = OP_READY && OP_VALID;

    assign EN_MAC    = ((r_state == c_S_LOAD) && !w_abort) || w_accept;
    assign RST_MAC   = (r_state == c_S_LOAD);
    assign BIAS_MAC  = r_bias;
    assign A_MAC     = OP_A;
    assign B_MAC     = OP_B;
    assign RES_VALID = (r_state == c_S_OUTPUT);
    assign RES_DATA  = r_res;
    assign BUSY      = (r_state != c_S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:   if (START) w_next = c_S_LOAD;
            c_S_LOAD:   w_next = (r_cnt != c_CNT_ZERO) ? c_S_ACCUM : c_S_DRAIN;
            c_S_ACCUM:  if (w_accept && (r_cnt == c_CNT_ONE)) w_next = c_S_DRAIN;
            c_S_DRAIN:  w_next = c_S_OUTPUT;
            c_S_OUTPUT: if (RES_READY) w_next = c_S_IDLE;
            default:    w_next = c_S_IDLE;
        endcase
        if (w_abort) begin
            w_next = c_S_IDLE;
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (RST_CTRL) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_bias  <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_S_IDLE) && START) begin
                r_cnt  <= LEN;
                r_bias <= BIAS;
            end else if (w_accept) begin
                // Job ends at count==1, so this never wraps below zero.
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            // MAC_Y is registered in the MAC, so the last accepted pair is
            // visible one cycle later, which is exactly the DRAIN cycle.
            if ((r_state == c_S_DRAIN) && !w_abort) begin
                r_res <= MAC_Y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_sequencer                                             |
// | Description : Self-checking bench for mac_sequencer. A behavioural         |
// |               saturating MAC closes the loop; expected results are queued  |
// |               when a job is issued and compared on the result handshake.   |
// | Optional    : honours `define MAC_SEQ_ABORT_EN                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mac_sequencer;

    logic        CLKEXT = 1'b0;
    logic        RST_CTRL;
    logic        ABORT;
    logic        START;
    logic [7:0]  LEN;
    logic [7:0]  BIAS;
    logic        OP_VALID;
    logic [7:0]  OP_A;
    logic [7:0]  OP_B;
    logic        OP_READY;
    logic        EN_MAC;
    logic        RST_MAC;
    logic [7:0]  BIAS_MAC;
    logic [7:0]  A_MAC;
    logic [7:0]  B_MAC;
    logic [15:0] MAC_Y;
    logic        RES_VALID;
    logic [15:0] RES_DATA;
    logic        RES_READY;
    logic        BUSY;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] q_exp[$];
    int pa[8];
    int pb[8];

    always #5 CLKEXT = ~CLKEXT;

    mac_sequencer #(.LEN_W(8)) u_dut (
        .CLKEXT    (CLKEXT),
        .RST_CTRL  (RST_CTRL),
`ifdef MAC_SEQ_ABORT_EN
        .ABORT     (ABORT),
`endif
        .START     (START),
        .LEN       (LEN),
        .BIAS      (BIAS),
        .OP_VALID  (OP_VALID),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .OP_READY  (OP_READY),
        .EN_MAC    (EN_MAC),
        .RST_MAC   (RST_MAC),
        .BIAS_MAC  (BIAS_MAC),
        .A_MAC     (A_MAC),
        .B_MAC     (B_MAC),
        .MAC_Y     (MAC_Y),
        .RES_VALID (RES_VALID),
        .RES_DATA  (RES_DATA),
        .RES_READY (RES_READY),
        .BUSY      (BUSY)
    );

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Behavioural registered MAC with saturation.
    logic signed [15:0] r_mac_acc = '0;
    always_ff @(posedge CLKEXT) begin
        if (EN_MAC === 1'b1) begin
            if (RST_MAC) r_mac_acc <= {8'd0, BIAS_MAC};
            else r_mac_acc <= 16'(sat16(int'(r_mac_acc) +
                                        int'($signed(A_MAC)) * int'($signed(B_MAC))));
        end
    end
    assign MAC_Y = r_mac_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLKEXT);
        #1;
    endtask

    // Runs one job: START in cycle 0, optional stall after stall_after pairs,
    // bp_n cycles of result back-pressure with a START pulse inside them.
    task automatic run_job(input int len, input int bias, input int stall_after,
                           input int stall_n, input int bp_n, input int exp_cyc);
        int acc = bias;
        int idx = 0, cyc = 1, stall_left = stall_n, bp_left = bp_n;
        int rdy_cnt = 0, en_cnt = 0, rst_cnt = 0;
        bit seen = 0, done = 0, stall;
        for (int i = 0; i < len; i++) acc = sat16(acc + pa[i] * pb[i]);
        q_exp.push_back(16'(acc));
        START = 1'b1; LEN = 8'(len); BIAS = 8'(bias);
        next_cycle();
        START = 1'b0; LEN = 8'($urandom); BIAS = 8'($urandom);
        while (!done && cyc < 200) begin
            stall = (idx == stall_after) && (stall_left > 0) && (idx < len);
            OP_VALID  = (idx < len) && !stall;
            OP_A      = OP_VALID ? 8'(pa[idx]) : 8'($urandom);
            OP_B      = OP_VALID ? 8'(pb[idx]) : 8'($urandom);
            RES_READY = (bp_left == 0);
            START     = seen && (bp_left == 2);
            #1;
            if (stall) begin
                stall_left--;
                check("en_in_stall", EN_MAC, 0);
            end
            if (cyc == 1) check("busy_in_load", BUSY, 1);
            rdy_cnt += OP_READY;
            en_cnt  += EN_MAC;
            rst_cnt += RST_MAC;
            if (OP_READY && OP_VALID) idx++;
            if (RES_VALID) begin
                if (!seen) check("res_valid_cycle", cyc, exp_cyc);
                seen = 1;
                check("res_data_stable", RES_DATA, q_exp.size() ? q_exp[0] : 16'hxxxx);
                if (RES_READY) begin
                    check("queue_nonempty", q_exp.size() > 0, 1);
                    if (q_exp.size() > 0) check("res_data", RES_DATA, q_exp.pop_front());
                    done = 1;
                end else begin
                    bp_left--;
                end
            end
            @(posedge CLKEXT);
            #1;
            cyc++;
        end
        if (!done) check("result_timeout", 0, 1);
        OP_VALID = 1'b0; RES_READY = 1'b0; START = 1'b0;
        check("pairs_accepted", idx, len);
        check("op_ready_cycles", rdy_cnt, len + stall_n);
        check("en_mac_cycles", en_cnt, len + 1);
        check("rst_mac_cycles", rst_cnt, 1);
        check("idle_busy", BUSY, 0);
        check("idle_res_valid", RES_VALID, 0);
    endtask

    // Starts a LEN=3 job and lets exactly one pair through, leaving the DUT in ACCUM.
    task automatic start_partial();
        START = 1'b1; LEN = 8'd3; BIAS = 8'd9;
        next_cycle();
        START = 1'b0;
        next_cycle();
        OP_VALID = 1'b1; OP_A = 8'd7; OP_B = 8'd7;
        next_cycle();
        OP_VALID = 1'b0;
    endtask

    initial begin
        RST_CTRL = 1'b1; ABORT = 1'b0; START = 1'b0; LEN = '0; BIAS = '0;
        OP_VALID = 1'b0; OP_A = '0; OP_B = '0; RES_READY = 1'b0;
        repeat (2) next_cycle();
        check("rst_op_ready", OP_READY, 0);
        check("rst_en_mac", EN_MAC, 0);
        check("rst_rst_mac", RST_MAC, 0);
        check("rst_bias_mac", BIAS_MAC, 0);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_res_data", RES_DATA, 0);
        check("rst_busy", BUSY, 0);
        RST_CTRL = 1'b0;
        next_cycle();

        // Basic job: 5 + 6 - 8 + 1 = 4
        pa[0] = 2;  pb[0] = 3;
        pa[1] = -4; pb[1] = 2;
        pa[2] = 1;  pb[2] = 1;
        run_job(3, 5, 0, 0, 0, 6);

        // Zero length returns the bias
        run_job(0, 200, 0, 0, 0, 3);

        // Two stall cycles between pairs
        pa[0] = 10; pb[0] = 10; pa[1] = 10; pb[1] = 10;
        run_job(2, 0, 1, 2, 0, 7);

        // Back-pressure with a START pulse during OUTPUT
        pa[0] = -3; pb[0] = 5;
        run_job(1, 17, 0, 0, 4, 4);

        // Saturation passthrough
        for (int i = 0; i < 4; i++) begin pa[i] = 127; pb[i] = 127; end
        run_job(4, 0, 0, 0, 0, 7);

        // Reset mid-ACCUM
        start_partial();
        RST_CTRL = 1'b1;
        next_cycle();
        check("midrst_op_ready", OP_READY, 0);
        check("midrst_en_mac", EN_MAC, 0);
        check("midrst_bias_mac", BIAS_MAC, 0);
        check("midrst_res_valid", RES_VALID, 0);
        check("midrst_res_data", RES_DATA, 0);
        check("midrst_busy", BUSY, 0);
        RST_CTRL = 1'b0;
        next_cycle();
        pa[0] = 2; pb[0] = 2;
        run_job(1, 1, 0, 0, 0, 4);

`ifdef MAC_SEQ_ABORT_EN
        // Abort in ACCUM with a same-cycle valid pair
        start_partial();
        ABORT = 1'b1; OP_VALID = 1'b1; OP_A = 8'd3; OP_B = 8'd3;
        #1;
        check("abort_en_mac", EN_MAC, 0);
        next_cycle();
        ABORT = 1'b0; OP_VALID = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_res_valid", RES_VALID, 0);
        next_cycle();
        pa[0] = 2; pb[0] = 2;
        run_job(1, 1, 0, 0, 0, 4);
`endif

        check("queue_drained", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
